// File: rtl/control_unit.sv
// Registered main decoder: opcode/Stall -> datapath control signals, one cycle latency.
// Build option: CONTROL_UNIT_STICKY_ILLEGAL_EN holds Illegal high until reset once it sets.
module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] opcode,
  input  logic       Stall,
  output logic       RegDst,
  output logic       Branch,
  output logic       MemRead,
  output logic       MemToReg,
  output logic [2:0] ALUop,
  output logic       MemWrite,
  output logic       ALUsrc,
  output logic       RegWrite,
  output logic       Illegal
);

  typedef enum logic [4:0] {
    OP_RTYPE = 5'h00,
    OP_ADDI  = 5'h01,
    OP_ANDI  = 5'h02,
    OP_ORI   = 5'h03,
    OP_SLTI  = 5'h04,
    OP_LW    = 5'h05,
    OP_SW    = 5'h06,
    OP_BEQ   = 5'h07,
    OP_XORI  = 5'h08,
    OP_LUI   = 5'h09,
    OP_NOP   = 5'h0A
  } opcode_e;

  typedef struct packed {
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic [2:0] alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
  } ctrl_t;

  ctrl_t ctrl_d, ctrl_q;
  logic  illegal_now;
  logic  illegal_d, illegal_q;

  // The all-zero word is simultaneously the reset value, NOP and the stall bubble.
  always_comb begin
    ctrl_d      = '0;
    illegal_now = 1'b0;
    if (!Stall) begin
      case (opcode)
        OP_RTYPE: begin
          ctrl_d.reg_dst   = 1'b1;
          ctrl_d.reg_write = 1'b1;
          ctrl_d.alu_op    = 3'b010;
        end
        OP_ADDI: begin
          ctrl_d.alu_src   = 1'b1;
          ctrl_d.reg_write = 1'b1;
          ctrl_d.alu_op    = 3'b000;
        end
        OP_ANDI: begin
          ctrl_d.alu_src   = 1'b1;
          ctrl_d.reg_write = 1'b1;
          ctrl_d.alu_op    = 3'b011;
        end
        OP_ORI: begin
          ctrl_d.alu_src   = 1'b1;
          ctrl_d.reg_write = 1'b1;
          ctrl_d.alu_op    = 3'b100;
        end
        OP_SLTI: begin
          ctrl_d.alu_src   = 1'b1;
          ctrl_d.reg_write = 1'b1;
          ctrl_d.alu_op    = 3'b101;
        end
        OP_LW: begin
          ctrl_d.alu_src    = 1'b1;
          ctrl_d.mem_read   = 1'b1;
          ctrl_d.mem_to_reg = 1'b1;
          ctrl_d.reg_write  = 1'b1;
          ctrl_d.alu_op     = 3'b000;
        end
        OP_SW: begin
          ctrl_d.alu_src   = 1'b1;
          ctrl_d.mem_write = 1'b1;
          ctrl_d.alu_op    = 3'b000;
        end
        OP_BEQ: begin
          ctrl_d.branch = 1'b1;
          ctrl_d.alu_op = 3'b001;
        end
        OP_XORI: begin
          ctrl_d.alu_src   = 1'b1;
          ctrl_d.reg_write = 1'b1;
          ctrl_d.alu_op    = 3'b110;
        end
        OP_LUI: begin
          ctrl_d.alu_src   = 1'b1;
          ctrl_d.reg_write = 1'b1;
          ctrl_d.alu_op    = 3'b111;
        end
        OP_NOP: ;
        default: illegal_now = 1'b1;
      endcase
    end
  end

`ifdef CONTROL_UNIT_STICKY_ILLEGAL_EN
  assign illegal_d = illegal_q | illegal_now;
`else
  assign illegal_d = illegal_now;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  assign RegDst   = ctrl_q.reg_dst;
  assign Branch   = ctrl_q.branch;
  assign MemRead  = ctrl_q.mem_read;
  assign MemToReg = ctrl_q.mem_to_reg;
  assign ALUop    = ctrl_q.alu_op;
  assign MemWrite = ctrl_q.mem_write;
  assign ALUsrc   = ctrl_q.alu_src;
  assign RegWrite = ctrl_q.reg_write;
  assign Illegal  = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: table-driven reference model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] opcode;
  logic       Stall;
  logic       RegDst, Branch, MemRead, MemToReg, MemWrite, ALUsrc, RegWrite, Illegal;
  logic [2:0] ALUop;

  int errors = 0;
  int checks = 0;
  logic run_cmp = 1'b0;

  control_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .Stall(Stall),
    .RegDst(RegDst), .Branch(Branch), .MemRead(MemRead), .MemToReg(MemToReg),
    .ALUop(ALUop), .MemWrite(MemWrite), .ALUsrc(ALUsrc), .RegWrite(RegWrite),
    .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  // Packed view: {RegDst,Branch,MemRead,MemToReg,ALUop[2:0],MemWrite,ALUsrc,RegWrite}
  logic [9:0] dut_ctrl;
  assign dut_ctrl = {RegDst, Branch, MemRead, MemToReg, ALUop, MemWrite, ALUsrc, RegWrite};

  // Reference model: decode table expressed as per-opcode attribute lists.
  int unsigned alu_tab [0:10] = '{2, 0, 3, 4, 5, 0, 0, 1, 6, 7, 0};
  logic [9:0] exp_ctrl;
  logic       exp_ill;

  function automatic logic [9:0] model_ctrl(input int unsigned op, input logic stall);
    logic [9:0] v;
    logic [2:0] a;
    v = '0;
    if (stall || op > 10) return v;
    a = alu_tab[op][2:0];
    v[9] = (op == 0);
    v[8] = (op == 7);
    v[7] = (op == 5);
    v[6] = (op == 5);
    v[5:3] = a;
    v[2] = (op == 6);
    v[1] = (op >= 1 && op <= 6) || op == 8 || op == 9;
    v[0] = (op <= 5) || op == 8 || op == 9;
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_ctrl = '0;
      exp_ill  = 1'b0;
    end else begin
      exp_ctrl = model_ctrl(int'(opcode), Stall);
`ifdef CONTROL_UNIT_STICKY_ILLEGAL_EN
      exp_ill  = exp_ill | (!Stall && opcode > 5'h0A);
`else
      exp_ill  = !Stall && opcode > 5'h0A;
`endif
    end
  end

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (run_cmp) begin
      check("model_ctrl", dut_ctrl, exp_ctrl);
      check("model_illegal", {9'd0, Illegal}, {9'd0, exp_ill});
      check("mutex_rd_wr", {9'd0, MemRead & MemWrite}, 10'd0);
      check("mutex_rw_wr", {9'd0, RegWrite & MemWrite}, 10'd0);
    end
  end

  task automatic step(input logic [4:0] op, input logic st);
    @(negedge clk);
    #1;
    opcode = op;
    Stall  = st;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst    = 1'b1;
    opcode = 5'h05;
    Stall  = 1'b0;
    #2;
    check("reset_ctrl", dut_ctrl, 10'd0);
    check("reset_illegal", {9'd0, Illegal}, 10'd0);
    @(posedge clk);
    #1;
    check("reset_hold_ctrl", dut_ctrl, 10'd0);
    @(negedge clk);
    rst = 1'b0;
    run_cmp = 1'b1;
    @(posedge clk);
    #1;
    check("lw_after_reset", dut_ctrl, 10'b0011000011);

    step(5'h00, 1'b0);
    check("rtype_row", dut_ctrl, 10'b1000010001);
    step(5'h01, 1'b0);
    check("addi_row", dut_ctrl, 10'b0000000011);
    step(5'h05, 1'b0);
    check("lw_row", dut_ctrl, 10'b0011000011);
    step(5'h0A, 1'b0);
    check("nop_row", dut_ctrl, 10'd0);
    check("nop_illegal", {9'd0, Illegal}, 10'd0);

    step(5'h1F, 1'b0);
    check("illegal_ctrl", dut_ctrl, 10'd0);
    check("illegal_flag", {9'd0, Illegal}, 10'd1);
    step(5'h06, 1'b0);
    check("sw_row", dut_ctrl, 10'b0000000110);
`ifdef CONTROL_UNIT_STICKY_ILLEGAL_EN
    check("sw_illegal_sticky", {9'd0, Illegal}, 10'd1);
`else
    check("sw_illegal", {9'd0, Illegal}, 10'd0);
`endif

    step(5'h07, 1'b1);
    check("stall_beq", dut_ctrl, 10'd0);
    step(5'h07, 1'b0);
    check("beq_row", dut_ctrl, 10'b0100001000);
    step(5'h15, 1'b1);
    check("stall_over_illegal_ctrl", dut_ctrl, 10'd0);

    // Asynchronous reset pulse between edges while the R-type row is showing.
    step(5'h00, 1'b0);
    check("rtype_before_pulse", dut_ctrl, 10'b1000010001);
    #1;
    rst = 1'b1;
    #1;
    check("async_reset_ctrl", dut_ctrl, 10'd0);
    check("async_reset_illegal", {9'd0, Illegal}, 10'd0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("first_decode_after_pulse", dut_ctrl, 10'b1000010001);

    // Mid-cycle opcode wiggle must not reach the outputs before the next edge.
    step(5'h07, 1'b0);
    opcode = 5'h05;
    #2;
    check("between_edges_hold", dut_ctrl, 10'b0100001000);

    for (int i = 0; i < 32; i++) step(5'(i), 1'b0);
    for (int i = 0; i < 8; i++) step(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));

    @(negedge clk);
    run_cmp = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock; all outputs registered on it.
REQ-002 rst  input  1  asynchronous active-high reset; clears every output register immediately, independent of clk.
REQ-003 opcode  input  5  instruction opcode field to decode.
REQ-004 Stall  input  1  when high, a bubble is loaded instead of the decode.
REQ-005 RegDst  output  1  destination register select; 1 = rd, 0 = rt.
REQ-006 Branch  output  1  conditional branch (BEQ).
REQ-007 MemRead  output  1  data-memory read enable.
REQ-008 MemToReg  output  1  writeback select; 1 = memory data, 0 = ALU result.
REQ-009 ALUop  output  3  ALU operation class.
REQ-010 MemWrite  output  1  data-memory write enable.
REQ-011 ALUsrc  output  1  ALU B operand; 1 = sign-extended immediate, 0 = register.
REQ-012 RegWrite  output  1  register-file write enable.
REQ-013 Illegal  output  1  opcode is not in the decode table.

Function
REQ-014 All outputs SHALL be registered with exactly one cycle of latency: the values after rising edge N reflect opcode and Stall sampled at edge N.
REQ-015 Decode table: fields not listed are 0.
- 0x00 R-type: RegDst=1, RegWrite=1, ALUop=010.
- 0x01 ADDI: ALUsrc=1, RegWrite=1, ALUop=000.
- 0x02 ANDI: ALUsrc=1, RegWrite=1, ALUop=011.
- 0x03 ORI: ALUsrc=1, RegWrite=1, ALUop=100.
- 0x04 SLTI: ALUsrc=1, RegWrite=1, ALUop=101.
- 0x05 LW: ALUsrc=1, MemRead=1, MemToReg=1, RegWrite=1, ALUop=000.
- 0x06 SW: ALUsrc=1, MemWrite=1, ALUop=000.
- 0x07 BEQ: Branch=1, ALUop=001.
- 0x08 XORI: ALUsrc=1, RegWrite=1, ALUop=110.
- 0x09 LUI: ALUsrc=1, RegWrite=1, ALUop=111.
- 0x0A NOP: all control outputs 0, Illegal=0 (legal opcode).
REQ-016 Opcodes 0x0B-0x1F SHALL load all control outputs 0 and set Illegal=1.
REQ-017 MemRead and MemWrite SHALL never both be 1; RegWrite and MemWrite SHALL never both be 1.
REQ-018 Stall=1 SHALL load the bubble (all control outputs 0, Illegal=0) regardless of opcode; Stall takes precedence over an illegal opcode.
REQ-019 Opcode changes between edges SHALL NOT affect the outputs until the next rising edge.

Reset
REQ-020 While rst=1, every output SHALL be 0 (ALUop=000), including Illegal; this value equals the NOP/bubble encoding.
REQ-021 Reset asserted mid-operation SHALL clear the outputs asynchronously; the first decode after release happens at the first rising edge with rst=0.

Configuration
REQ-022 Macro CONTROL_UNIT_STICKY_ILLEGAL_EN:
- Defined: once set, Illegal SHALL stay 1 until rst, even through later legal opcodes and Stall cycles.
- Undefined: Illegal SHALL be re-evaluated every cycle per REQ-016/REQ-018.
- All other outputs SHALL be identical in both builds.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- rst=1 with opcode=0x05 -> all outputs 0; release rst, one edge -> LW: ALUsrc=1, MemRead=1, MemToReg=1, RegWrite=1, ALUop=000.
- opcode 0x00, 0x01, 0x05, 0x0A on consecutive edges -> each edge shows its table row one cycle later; 0x0A gives all zeros with Illegal=0.
- opcode=0x1F -> all controls 0, Illegal=1; then 0x06 -> SW row; Illegal=0 without the macro, 1 with it.
- Stall=1 with opcode=0x07 -> all zeros; Stall=0 -> Branch=1, ALUop=001.
- rst pulsed between clock edges while the outputs show the R-type row -> outputs 0 immediately, before the next edge.
- Sweep opcode 0x00-0x1F -> outputs match the table; MemRead&MemWrite and RegWrite&MemWrite are never 1.
